chu_gpi_edge: RTL and testbench

//  Next-generation general-purpose input slot core for the FPro MMIO bus.

---
 rtl/chu_gpi_pkg.sv | 14 +
 rtl/chu_gpi_sync_db.sv | 66 ++++++
 rtl/chu_gpi_edge.sv | 91 +++++++++
 tb/tb_chu_gpi_edge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/chu_gpi_pkg.sv
// chu_gpi_pkg
//   Register word offsets for the GPI slot core (addr[2:0]), plus the data
//   bus width shared by every FPro MMIO slot core.
package chu_gpi_pkg;

   localparam int unsigned BUS_W = 32;

   localparam logic [2:0] GPI_REG_DATA = 3'd0;  // RO   filtered input level
   localparam logic [2:0] GPI_REG_EDGE = 3'd1;  // RW1C sticky edge flags
   localparam logic [2:0] GPI_REG_RISE = 3'd2;  // RW   rising-edge enables
   localparam logic [2:0] GPI_REG_FALL = 3'd3;  // RW   falling-edge enables
   localparam logic [2:0] GPI_REG_IE   = 3'd4;  // RW   interrupt enables

endpackage

// File: rtl/chu_gpi_sync_db.sv
// chu_gpi_sync_db
//   Synchroniser chain followed by an optional sampling debouncer.
//   Ports:
//     clk     system clock
//     reset   synchronous reset, active-low
//     din     asynchronous inputs, W bits
//     db_reg  synchronised (and, if DB_DIV>0, debounced) input level
module chu_gpi_sync_db #(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_DIV      = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] db_reg
);

   logic [SYNC_STAGES-1:0][W-1:0] sync_q;
   logic [W-1:0]                  s;

   always_ff @(posedge clk) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

   assign s = sync_q[SYNC_STAGES-1];

   if (DB_DIV == 0) begin : g_bypass

      always_ff @(posedge clk) begin
         if (!reset) db_reg <= '0;
         else        db_reg <= s;
      end

   end else begin : g_debounce

      localparam int          CW   = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
      localparam logic [CW-1:0] LAST = CW'(DB_DIV - 1);

      logic [CW-1:0] count;
      logic [W-1:0]  smp;
      logic [W-1:0]  stable;
      logic          tick;

      assign tick   = (count == LAST);
      // A bit is accepted only when two consecutive tick samples agree.
      assign stable = ~(s ^ smp);

      always_ff @(posedge clk) begin
         if (!reset) begin
            count  <= '0;
            smp    <= '0;
            db_reg <= '0;
         end else if (tick) begin
            count  <= '0;
            smp    <= s;
            db_reg <= (db_reg & ~stable) | (s & stable);
         end else begin
            count  <= count + CW'(1);
         end
      end

   end

endmodule

// File: rtl/chu_gpi_edge.sv
// chu_gpi_edge
//   GPI slot core: synchronised/debounced inputs, programmable sticky edge
//   flags (write-1-to-clear) and a maskable registered level interrupt.
//   Ports:
//     clk, reset      system clock, synchronous active-low reset
//     cs, read, write slot select and strobes (read has no side effects)
//     addr            word address, addr[2:0] decoded
//     wr_data         write data, bits [31:W] ignored
//     rd_data         combinational readback, bits [31:W] zero
//     din             asynchronous external inputs
//     irq             |(edge flags & interrupt enables), registered
module chu_gpi_edge
   import chu_gpi_pkg::*;
#(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_DIV      = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             read,
   input  logic             write,
   input  logic [4:0]       addr,
   input  logic [BUS_W-1:0] wr_data,
   output logic [BUS_W-1:0] rd_data,
   input  logic [W-1:0]     din,
   output logic             irq
);

   logic [W-1:0] db_reg, db_prev;
   logic [W-1:0] edge_reg, rise_en, fall_en, ie_reg;
   logic [W-1:0] rise, fall, clr, edge_next, ie_next;
   logic [2:0]   sel;
   logic         wr_en;
   logic         unused_bits;

   chu_gpi_sync_db #(
      .W           (W),
      .SYNC_STAGES (SYNC_STAGES),
      .DB_DIV      (DB_DIV)
   ) u_sync_db (
      .clk    (clk),
      .reset  (reset),
      .din    (din),
      .db_reg (db_reg)
   );

   assign sel         = addr[2:0];
   assign wr_en       = cs & write;
   assign unused_bits = ^{read, addr[4:3], wr_data};

   assign rise = db_reg & ~db_prev & rise_en;
   assign fall = ~db_reg & db_prev & fall_en;
   assign clr  = (wr_en && sel == GPI_REG_EDGE) ? wr_data[W-1:0] : '0;

   // New edges are OR-ed in after the clear so a coincident set wins.
   assign edge_next = (edge_reg & ~clr) | rise | fall;
   assign ie_next   = (wr_en && sel == GPI_REG_IE) ? wr_data[W-1:0] : ie_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         db_prev  <= '0;
         edge_reg <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
         ie_reg   <= '0;
         irq      <= 1'b0;
      end else begin
         db_prev  <= db_reg;
         edge_reg <= edge_next;
         ie_reg   <= ie_next;
         irq      <= |(edge_next & ie_next);
         if (wr_en && sel == GPI_REG_RISE) rise_en <= wr_data[W-1:0];
         if (wr_en && sel == GPI_REG_FALL) fall_en <= wr_data[W-1:0];
      end
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         GPI_REG_DATA: rd_data[W-1:0] = db_reg;
         GPI_REG_EDGE: rd_data[W-1:0] = edge_reg;
         GPI_REG_RISE: rd_data[W-1:0] = rise_en;
         GPI_REG_FALL: rd_data[W-1:0] = fall_en;
         GPI_REG_IE:   rd_data[W-1:0] = ie_reg;
         default:      rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_chu_gpi_edge.sv
module tb_chu_gpi_edge;

   logic        clk;
   logic        reset;
   logic        cs, read, write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [7:0]  din;
   logic [31:0] rd0, rd16;
   logic        irq0, irq16;

   int n_tests = 0;
   int n_fail  = 0;

   chu_gpi_edge #(.W(8), .SYNC_STAGES(2), .DB_DIV(0)) dut0 (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd0), .din(din), .irq(irq0)
   );

   chu_gpi_edge #(.W(8), .SYNC_STAGES(2), .DB_DIV(16)) dut16 (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd16), .din(din), .irq(irq16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  din;
      logic        wr;
      logic        wcs;
      logic [2:0]  waddr;
      logic [31:0] wdata;
      int          nwait;
      logic [2:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   localparam int NV = 19;
   vec_t vec [NV];

   function automatic vec_t mk(input logic [7:0] d, input logic w, input logic c,
                               input logic [2:0] wa, input logic [31:0] wd, input int nw,
                               input logic [2:0] ra, input logic [31:0] er, input logic ei);
      vec_t v;
      v.din = d; v.wr = w; v.wcs = c; v.waddr = wa; v.wdata = wd; v.nwait = nw;
      v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic c);
      cs = c; write = 1'b1; addr = {2'b10, a}; wr_data = d;
      @(posedge clk);
      @(negedge clk);
      cs = 1'b0; write = 1'b0; wr_data = '0;
   endtask

   task automatic rd_check(input string name, input logic [2:0] a,
                           input logic use16, input logic [31:0] exp);
      addr = {2'b01, a}; read = 1'b1;
      #1;
      check(name, use16 ? rd16 : rd0, exp);
      read = 1'b0;
   endtask

   initial begin
      bit seen;
      bit found;

      // addr: 0 DATA, 1 EDGE, 2 RISE, 3 FALL, 4 IE
      vec[0]  = mk(8'hA5, 1, 1, 3'd2, 32'h01,       1, 3'd2, 32'h01, 0);
      vec[1]  = mk(8'hA5, 1, 1, 3'd4, 32'h01,       1, 3'd4, 32'h01, 0);
      vec[2]  = mk(8'hA5, 1, 1, 3'd3, 32'h80,       1, 3'd3, 32'h80, 0);
      vec[3]  = mk(8'hA4, 0, 0, 3'd0, 32'h00,       6, 3'd1, 32'h00, 0);
      vec[4]  = mk(8'hA4, 0, 0, 3'd0, 32'h00,       1, 3'd0, 32'hA4, 0);
      vec[5]  = mk(8'hA5, 0, 0, 3'd0, 32'h00,       6, 3'd1, 32'h01, 1);
      vec[6]  = mk(8'hA5, 1, 1, 3'd1, 32'h01,       1, 3'd1, 32'h00, 0);
      vec[7]  = mk(8'hA4, 0, 0, 3'd0, 32'h00,       6, 3'd1, 32'h00, 0);
      vec[8]  = mk(8'hA4, 1, 1, 3'd4, 32'h00,       1, 3'd4, 32'h00, 0);
      vec[9]  = mk(8'h24, 0, 0, 3'd0, 32'h00,       6, 3'd1, 32'h80, 0);
      vec[10] = mk(8'h24, 1, 1, 3'd4, 32'h80,       1, 3'd1, 32'h80, 1);
      vec[11] = mk(8'h24, 1, 1, 3'd2, 32'h00,       1, 3'd1, 32'h80, 1);
      vec[12] = mk(8'h24, 1, 1, 3'd1, 32'h7F,       1, 3'd1, 32'h80, 1);
      vec[13] = mk(8'h24, 1, 0, 3'd4, 32'h00,       1, 3'd4, 32'h80, 1);
      vec[14] = mk(8'h24, 1, 1, 3'd5, 32'hFF,       1, 3'd5, 32'h00, 1);
      vec[15] = mk(8'h24, 1, 1, 3'd3, 32'h00,       1, 3'd1, 32'h80, 1);
      vec[16] = mk(8'h24, 1, 1, 3'd1, 32'h80,       1, 3'd1, 32'h00, 0);
      vec[17] = mk(8'h24, 1, 1, 3'd2, 32'hFFFFFF04, 1, 3'd2, 32'h04, 0);
      vec[18] = mk(8'h24, 0, 0, 3'd0, 32'h00,       1, 3'd0, 32'h24, 0);

      // Reset with inputs high
      reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
      addr = '0; wr_data = '0; din = 8'hFF;
      repeat (3) @(negedge clk);
      for (int a = 0; a < 8; a++) begin
         rd_check($sformatf("reset_rd0_a%0d", a), 3'(a), 1'b0, 32'h0);
         rd_check($sformatf("reset_rd16_a%0d", a), 3'(a), 1'b1, 32'h0);
      end
      check("reset_irq0", {31'b0, irq0}, 32'h0);
      check("reset_irq16", {31'b0, irq16}, 32'h0);
      reset = 1'b1;

      // DATA latency with the debouncer bypassed
      din = 8'h00;
      repeat (5) @(negedge clk);
      din = 8'hA5;
      repeat (2) @(negedge clk);
      rd_check("latency_early", 3'd0, 1'b0, 32'h00);
      @(negedge clk);
      rd_check("latency_exact", 3'd0, 1'b0, 32'hA5);

      // Register/edge/irq vectors
      for (int i = 0; i < NV; i++) begin
         din = vec[i].din;
         if (vec[i].wr) bus_write(vec[i].waddr, vec[i].wdata, vec[i].wcs);
         else           @(negedge clk);
         repeat (vec[i].nwait - 1) @(negedge clk);
         rd_check($sformatf("vec%0d_rd", i), vec[i].raddr, 1'b0, vec[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'b0, irq0}, {31'b0, vec[i].exp_irq});
      end

      // W1C collision: rising edge on bit 2 lands on the same edge as its clear
      bus_write(3'd4, 32'h04, 1'b1);
      din = 8'h20;
      repeat (6) @(negedge clk);
      rd_check("coll_pre_idle", 3'd1, 1'b0, 32'h00);
      din = 8'h24;
      repeat (3) @(negedge clk);
      rd_check("coll_pre_edge", 3'd1, 1'b0, 32'h00);
      check("coll_pre_irq", {31'b0, irq0}, 32'h0);
      bus_write(3'd1, 32'h04, 1'b1);
      rd_check("coll_set_wins", 3'd1, 1'b0, 32'h04);
      check("coll_irq", {31'b0, irq0}, 32'h1);
      bus_write(3'd1, 32'h04, 1'b1);
      rd_check("coll_clear", 3'd1, 1'b0, 32'h00);
      check("coll_clear_irq", {31'b0, irq0}, 32'h0);

      // Debounce with DB_DIV=16
      din = 8'h00;
      repeat (40) @(negedge clk);
      rd_check("db_settle", 3'd0, 1'b1, 32'h00);
      seen = 1'b0;
      din = 8'h08;
      addr = {2'b00, 3'd0};
      for (int k = 0; k < 60; k++) begin
         if (k == 10) din = 8'h00;
         @(negedge clk);
         #1;
         if (rd16[3]) seen = 1'b1;
      end
      check("db_glitch_never_seen", {31'b0, seen}, 32'h0);
      rd_check("db_glitch_data", 3'd0, 1'b1, 32'h00);

      found = 1'b0;
      din = 8'h08;
      addr = {2'b00, 3'd0};
      for (int k = 0; k < 35 && !found; k++) begin
         @(negedge clk);
         #1;
         if (rd16[3]) found = 1'b1;
      end
      check("db_level_accepted", {31'b0, found}, 32'h1);
      rd_check("db_level_data", 3'd0, 1'b1, 32'h08);

      // Reset mid-count with din[3] still high
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      for (int a = 0; a < 8; a++)
         rd_check($sformatf("db_reset_a%0d", a), 3'(a), 1'b1, 32'h0);
      check("db_reset_irq", {31'b0, irq16}, 32'h0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      rd_check("db_after_reset_partial", 3'd0, 1'b1, 32'h00);
      repeat (16) @(negedge clk);
      rd_check("db_after_reset_settled", 3'd0, 1'b1, 32'h08);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
